// File: rtl/uart_tx_param.sv
// ============================================================================
// Module   : uart_tx_param
// Brief    : FIFO-buffered UART transmitter, optional parity under UART_TX_PARITY_EN
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_param #(
   parameter int DATA_BITS   = 8,
   parameter int CLK_PER_BIT = 10416,
   parameter int FIFO_DEPTH  = 16
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic [DATA_BITS-1:0]          s_data,
   input  logic                          s_valid,
   output logic                          s_ready,
   input  logic                          cfg_two_stop,
   input  logic [1:0]                    cfg_parity,
   output logic                          txd,
   output logic                          tx_busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int BW = $clog2(CLK_PER_BIT);
   localparam int IW = $clog2(DATA_BITS);

   localparam logic [CW-1:0] c_depth    = CW'(FIFO_DEPTH);
   localparam logic [BW-1:0] c_bit_last = BW'(CLK_PER_BIT - 1);
   localparam logic [IW-1:0] c_idx_last = IW'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr_q;
   logic [AW-1:0]        rd_ptr_q;
   logic [CW-1:0]        count_q;

   state_t               state_q;
   logic [BW-1:0]        bit_cnt_q;
   logic [IW-1:0]        idx_q;
   logic [DATA_BITS-1:0] shreg_q;
   logic                 two_stop_q;
   logic                 stop2_q;
   logic                 txd_q;
   logic                 busy_q;

   logic                 w_push;
   logic                 w_pop;
   logic                 w_bit_end;
   logic                 w_stop_done;
   logic [DATA_BITS-1:0] w_head;

`ifdef UART_TX_PARITY_EN
   logic                 par_en_q;
   logic                 par_bit_q;
`else
   logic                 cfg_parity_unused;
   assign cfg_parity_unused = ^cfg_parity;
`endif

   assign s_ready    = rstn && (count_q != c_depth);
   assign txd        = txd_q;
   assign tx_busy    = busy_q;
   assign fifo_count = count_q;

   assign w_push      = s_valid && s_ready;
   assign w_head      = mem_q[rd_ptr_q];
   assign w_bit_end   = (bit_cnt_q == c_bit_last);
   assign w_stop_done = (state_q == S_STOP) && w_bit_end && (!two_stop_q || stop2_q);
   // Pop either from idle or on the very last stop cycle, so frames abut.
   assign w_pop       = (count_q != '0) && ((state_q == S_IDLE) || w_stop_done);

   always_ff @(posedge clk) begin
      if (w_push) begin
         mem_q[wr_ptr_q] <= s_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (w_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (w_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({w_push, w_pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // txd is driven from the state of the previous cycle, one edge behind the pop.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q    <= S_IDLE;
         bit_cnt_q  <= '0;
         idx_q      <= '0;
         shreg_q    <= '0;
         two_stop_q <= 1'b0;
         stop2_q    <= 1'b0;
         txd_q      <= 1'b1;
         busy_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_en_q   <= 1'b0;
         par_bit_q  <= 1'b0;
`endif
      end else begin
         busy_q <= (state_q != S_IDLE) || (count_q != '0);

         if ((state_q == S_IDLE) || w_bit_end) bit_cnt_q <= '0;
         else                                  bit_cnt_q <= bit_cnt_q + BW'(1);

         if (w_pop) begin
            shreg_q    <= w_head;
            two_stop_q <= cfg_two_stop;
            stop2_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_q   <= cfg_parity[0] ^ cfg_parity[1];
            par_bit_q  <= (^w_head) ^ cfg_parity[1];
`endif
         end

         case (state_q)
            S_IDLE: begin
               txd_q <= 1'b1;
               if (w_pop) state_q <= S_START;
            end
            S_START: begin
               txd_q <= 1'b0;
               if (w_bit_end) begin
                  idx_q   <= '0;
                  state_q <= S_DATA;
               end
            end
            S_DATA: begin
               txd_q <= shreg_q[0];
               if (w_bit_end) begin
                  shreg_q <= shreg_q >> 1;
                  if (idx_q == c_idx_last) begin
`ifdef UART_TX_PARITY_EN
                     state_q <= par_en_q ? S_PARITY : S_STOP;
`else
                     state_q <= S_STOP;
`endif
                  end else begin
                     idx_q <= idx_q + IW'(1);
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
               txd_q <= par_bit_q;
               if (w_bit_end) state_q <= S_STOP;
            end
`endif
            S_STOP: begin
               txd_q <= 1'b1;
               if (w_bit_end) begin
                  if (two_stop_q && !stop2_q) stop2_q <= 1'b1;
                  else if (w_pop)             state_q <= S_START;
                  else                        state_q <= S_IDLE;
               end
            end
            default: begin
               txd_q   <= 1'b1;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire
